// File: rtl/bank_request_buffer.sv
// Per-bank request buffer: sorts mapped requests into separate read and write FIFOs,
// raises busy toward the mapper and presents FIFO heads with row-hit flags to the scheduler.

module brq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count,
   output logic             o_overflow
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_CNT);
   assign w_do_pop  = i_pop & ~w_empty;
   // A pop on a full FIFO frees the slot the same edge, so the push is still taken.
   assign w_do_push = i_push & (~w_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_head     = r_mem[r_rd_ptr];
   assign o_valid    = ~w_empty;
   assign o_count    = r_count;
   assign o_overflow = i_push & w_full & ~w_do_pop;

endmodule

module bank_request_buffer #(
   parameter int ROW_W    = 16,
   parameter int COL_W    = 10,
   parameter int DATA_W   = 32,
   parameter int RD_IDX_W = 4,
   parameter int WR_IDX_W = 4,
   parameter int RD_DEPTH = 8,
   parameter int WR_DEPTH = 8,
   localparam int IDX_W    = (RD_IDX_W > WR_IDX_W) ? RD_IDX_W : WR_IDX_W,
   localparam int RD_CNT_W = $clog2(RD_DEPTH) + 1,
   localparam int WR_CNT_W = $clog2(WR_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic                in_type,
   input  logic [ROW_W-1:0]    in_row,
   input  logic [COL_W-1:0]    in_col,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [IDX_W-1:0]    in_index,
   output logic                busy_o,
   input  logic [ROW_W-1:0]    open_row,
   input  logic                open_row_valid,
   output logic                rd_valid_o,
   output logic [ROW_W-1:0]    rd_row_o,
   output logic [COL_W-1:0]    rd_col_o,
   output logic [RD_IDX_W-1:0] rd_index_o,
   output logic                rd_hit_o,
   input  logic                rd_pop,
   output logic                wr_valid_o,
   output logic [ROW_W-1:0]    wr_row_o,
   output logic [COL_W-1:0]    wr_col_o,
   output logic [DATA_W-1:0]   wr_data_o,
   output logic [WR_IDX_W-1:0] wr_index_o,
   output logic                wr_hit_o,
   input  logic                wr_pop,
   output logic [RD_CNT_W-1:0] rd_count_o,
   output logic [WR_CNT_W-1:0] wr_count_o,
   output logic                overflow_err_o
);

   localparam int RD_ENT_W = ROW_W + COL_W + RD_IDX_W;
   localparam int WR_ENT_W = ROW_W + COL_W + DATA_W + WR_IDX_W;
   // One free slot is kept in reserve for the request already in flight from the mapper.
   localparam logic [RD_CNT_W-1:0] RD_BUSY_TH = RD_CNT_W'(RD_DEPTH - 1);
   localparam logic [WR_CNT_W-1:0] WR_BUSY_TH = WR_CNT_W'(WR_DEPTH - 1);

   logic                w_rd_push;
   logic                w_wr_push;
   logic [RD_ENT_W-1:0] w_rd_entry_in;
   logic [WR_ENT_W-1:0] w_wr_entry_in;
   logic [RD_ENT_W-1:0] w_rd_head;
   logic [WR_ENT_W-1:0] w_wr_head;
   logic                w_rd_overflow;
   logic                w_wr_overflow;
   logic                r_overflow_err;

   assign w_rd_push     = in_valid & ~in_type;
   assign w_wr_push     = in_valid & in_type;
   assign w_rd_entry_in = {in_row, in_col, in_index[RD_IDX_W-1:0]};
   assign w_wr_entry_in = {in_row, in_col, in_data, in_index[WR_IDX_W-1:0]};

   brq_fifo #(
      .WIDTH (RD_ENT_W),
      .DEPTH (RD_DEPTH)
   ) u_rd_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_rd_push),
      .i_push_data (w_rd_entry_in),
      .i_pop       (rd_pop),
      .o_head      (w_rd_head),
      .o_valid     (rd_valid_o),
      .o_count     (rd_count_o),
      .o_overflow  (w_rd_overflow)
   );

   brq_fifo #(
      .WIDTH (WR_ENT_W),
      .DEPTH (WR_DEPTH)
   ) u_wr_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_wr_push),
      .i_push_data (w_wr_entry_in),
      .i_pop       (wr_pop),
      .o_head      (w_wr_head),
      .o_valid     (wr_valid_o),
      .o_count     (wr_count_o),
      .o_overflow  (w_wr_overflow)
   );

   assign {rd_row_o, rd_col_o, rd_index_o}            = w_rd_head;
   assign {wr_row_o, wr_col_o, wr_data_o, wr_index_o} = w_wr_head;

   assign rd_hit_o = rd_valid_o & open_row_valid & (rd_row_o == open_row);
   assign wr_hit_o = wr_valid_o & open_row_valid & (wr_row_o == open_row);

   assign busy_o = (rd_count_o >= RD_BUSY_TH) | (wr_count_o >= WR_BUSY_TH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow_err <= 1'b0;
      end else if (w_rd_overflow || w_wr_overflow) begin
         r_overflow_err <= 1'b1;
      end
   end

   assign overflow_err_o = r_overflow_err;

endmodule

// File: tb/tb_bank_request_buffer.sv
// Directed testbench for bank_request_buffer: ordering, busy/overflow, full push+pop,
// pointer wrap, row-hit flags and mid-operation reset.

module tb_bank_request_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_type;
   logic [15:0] in_row;
   logic [9:0]  in_col;
   logic [31:0] in_data;
   logic [3:0]  in_index;
   logic        busy_o;
   logic [15:0] open_row;
   logic        open_row_valid;
   logic        rd_valid_o;
   logic [15:0] rd_row_o;
   logic [9:0]  rd_col_o;
   logic [3:0]  rd_index_o;
   logic        rd_hit_o;
   logic        rd_pop;
   logic        wr_valid_o;
   logic [15:0] wr_row_o;
   logic [9:0]  wr_col_o;
   logic [31:0] wr_data_o;
   logic [3:0]  wr_index_o;
   logic        wr_hit_o;
   logic        wr_pop;
   logic [3:0]  rd_count_o;
   logic [3:0]  wr_count_o;
   logic        overflow_err_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bank_request_buffer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_type        (in_type),
      .in_row         (in_row),
      .in_col         (in_col),
      .in_data        (in_data),
      .in_index       (in_index),
      .busy_o         (busy_o),
      .open_row       (open_row),
      .open_row_valid (open_row_valid),
      .rd_valid_o     (rd_valid_o),
      .rd_row_o       (rd_row_o),
      .rd_col_o       (rd_col_o),
      .rd_index_o     (rd_index_o),
      .rd_hit_o       (rd_hit_o),
      .rd_pop         (rd_pop),
      .wr_valid_o     (wr_valid_o),
      .wr_row_o       (wr_row_o),
      .wr_col_o       (wr_col_o),
      .wr_data_o      (wr_data_o),
      .wr_index_o     (wr_index_o),
      .wr_hit_o       (wr_hit_o),
      .wr_pop         (wr_pop),
      .rd_count_o     (rd_count_o),
      .wr_count_o     (wr_count_o),
      .overflow_err_o (overflow_err_o)
   );

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic t, input logic [15:0] row, input logic [9:0] col,
                       input logic [31:0] data, input logic [3:0] idx);
      in_valid = 1'b1;
      in_type  = t;
      in_row   = row;
      in_col   = col;
      in_data  = data;
      in_index = idx;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid_o); end
      checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid_o); end
      checks++; if (rd_count_o !== 4'd0) begin errors++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count_o); end
      checks++; if (wr_count_o !== 4'd0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count_o); end
      checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_err_o); end
      $display("reset: busy=%b rd_valid=%b wr_valid=%b", busy_o, rd_valid_o, wr_valid_o);
   endtask

   task automatic test_read_order();
      push(1'b0, 16'd5, 10'd1, 32'h0, 4'd0);
      push(1'b0, 16'd6, 10'd2, 32'h0, 4'd1);
      checks++; if (rd_count_o !== 4'd2) begin errors++; $display("FAIL order_count2: got %0d expected 2", rd_count_o); end
      checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL order_valid: got %b expected 1", rd_valid_o); end
      checks++; if (rd_row_o !== 16'd5 || rd_col_o !== 10'd1 || rd_index_o !== 4'd0) begin
         errors++; $display("FAIL order_head0: got row=%0d col=%0d idx=%0d expected 5/1/0", rd_row_o, rd_col_o, rd_index_o); end
      checks++; if (wr_valid_o !== 1'b0 || wr_count_o !== 4'd0) begin
         errors++; $display("FAIL order_wr_untouched: got valid=%b count=%0d expected 0/0", wr_valid_o, wr_count_o); end
      rd_pop = 1'b1; tick(); rd_pop = 1'b0;
      checks++; if (rd_row_o !== 16'd6 || rd_col_o !== 10'd2 || rd_index_o !== 4'd1) begin
         errors++; $display("FAIL order_head1: got row=%0d col=%0d idx=%0d expected 6/2/1", rd_row_o, rd_col_o, rd_index_o); end
      rd_pop = 1'b1; tick(); rd_pop = 1'b0;
      checks++; if (rd_valid_o !== 1'b0 || rd_count_o !== 4'd0) begin
         errors++; $display("FAIL order_empty: got valid=%b count=%0d expected 0/0", rd_valid_o, rd_count_o); end
      rd_pop = 1'b1; tick(); rd_pop = 1'b0;
      checks++; if (rd_count_o !== 4'd0 || overflow_err_o !== 1'b0) begin
         errors++; $display("FAIL order_pop_empty: got count=%0d ovf=%b expected 0/0", rd_count_o, overflow_err_o); end
      $display("read_order: two reads pushed and popped in order");
   endtask

   task automatic test_busy_overflow();
      for (int i = 0; i < 6; i++) push(1'b0, 16'(100 + i), 10'(i), 32'h0, 4'(i));
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_at6: got %b expected 0", busy_o); end
      push(1'b0, 16'd106, 10'd6, 32'h0, 4'd6);
      checks++; if (busy_o !== 1'b1 || rd_count_o !== 4'd7) begin
         errors++; $display("FAIL busy_at7: got busy=%b count=%0d expected 1/7", busy_o, rd_count_o); end
      push(1'b0, 16'd107, 10'd7, 32'h0, 4'd7);
      checks++; if (rd_count_o !== 4'd8 || overflow_err_o !== 1'b0) begin
         errors++; $display("FAIL full8: got count=%0d ovf=%b expected 8/0", rd_count_o, overflow_err_o); end
      push(1'b0, 16'd999, 10'd9, 32'h0, 4'd9);
      checks++; if (rd_count_o !== 4'd8 || overflow_err_o !== 1'b1) begin
         errors++; $display("FAIL overflow: got count=%0d ovf=%b expected 8/1", rd_count_o, overflow_err_o); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (rd_row_o !== 16'(100 + i)) begin
            errors++; $display("FAIL drain_row%0d: got %0d expected %0d", i, rd_row_o, 100 + i); end
         rd_pop = 1'b1; tick(); rd_pop = 1'b0;
      end
      checks++; if (rd_valid_o !== 1'b0 || busy_o !== 1'b0 || overflow_err_o !== 1'b1) begin
         errors++; $display("FAIL drained: got valid=%b busy=%b ovf=%b expected 0/0/1", rd_valid_o, busy_o, overflow_err_o); end
      $display("busy_overflow: busy at 7, ninth read dropped, overflow held");
   endtask

   task automatic test_full_push_pop();
      do_reset();
      checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", overflow_err_o); end
      for (int i = 0; i < 7; i++) push(1'b1, 16'(i), 10'(i), 32'h1000 + 32'(i), 4'(i));
      checks++; if (busy_o !== 1'b1 || wr_count_o !== 4'd7) begin
         errors++; $display("FAIL wr_busy7: got busy=%b count=%0d expected 1/7", busy_o, wr_count_o); end
      push(1'b1, 16'd7, 10'd7, 32'h1007, 4'd7);
      checks++; if (wr_count_o !== 4'd8) begin errors++; $display("FAIL wr_full: got %0d expected 8", wr_count_o); end
      wr_pop = 1'b1;
      push(1'b1, 16'h0055, 10'd3, 32'hA5A5A5A5, 4'd15);
      wr_pop = 1'b0;
      checks++; if (wr_count_o !== 4'd8 || overflow_err_o !== 1'b0) begin
         errors++; $display("FAIL full_push_pop: got count=%0d ovf=%b expected 8/0", wr_count_o, overflow_err_o); end
      for (int i = 1; i < 8; i++) begin
         checks++; if (wr_data_o !== 32'h1000 + 32'(i)) begin
            errors++; $display("FAIL full_drain%0d: got %h expected %h", i, wr_data_o, 32'h1000 + 32'(i)); end
         wr_pop = 1'b1; tick(); wr_pop = 1'b0;
      end
      checks++; if (wr_data_o !== 32'hA5A5A5A5 || wr_row_o !== 16'h0055 || wr_index_o !== 4'd15) begin
         errors++; $display("FAIL a5_head: got data=%h row=%h idx=%0d expected a5a5a5a5/0055/15", wr_data_o, wr_row_o, wr_index_o); end
      wr_pop = 1'b1; tick(); wr_pop = 1'b0;
      checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL wr_empty: got %b expected 0", wr_valid_o); end
      $display("full_push_pop: simultaneous push/pop on full write FIFO accepted");
   endtask

   task automatic test_wrap();
      int pushed = 0;
      int popped = 0;
      for (int k = 0; k < 60 && popped < 20; k++) begin
         logic dp, dq;
         dp = (pushed < 20);
         dq = ((pushed - popped) >= 3) || (pushed == 20 && pushed > popped);
         if (dq) begin
            checks++; if (wr_data_o !== 32'hC0DE0000 + 32'(popped)) begin
               errors++; $display("FAIL wrap_head%0d: got %h expected %h", popped, wr_data_o, 32'hC0DE0000 + 32'(popped)); end
         end
         wr_pop = dq;
         if (dp) push(1'b1, 16'(pushed), 10'd0, 32'hC0DE0000 + 32'(pushed), 4'(pushed));
         else tick();
         wr_pop = 1'b0;
         if (dp) pushed++;
         if (dq) popped++;
         checks++; if (wr_count_o !== 4'(pushed - popped)) begin
            errors++; $display("FAIL wrap_count: got %0d expected %0d", wr_count_o, pushed - popped); end
      end
      checks++; if (popped != 20) begin errors++; $display("FAIL wrap_done: got %0d pops expected 20", popped); end
      $display("wrap: 20 writes streamed through write FIFO");
   endtask

   task automatic test_hit_reset();
      do_reset();
      push(1'b0, 16'h0012, 10'd4, 32'h0, 4'd2);
      open_row = 16'h0012; open_row_valid = 1'b1;
      #1;
      checks++; if (rd_hit_o !== 1'b1) begin errors++; $display("FAIL hit_match: got %b expected 1", rd_hit_o); end
      open_row = 16'h0013;
      #1;
      checks++; if (rd_hit_o !== 1'b0) begin errors++; $display("FAIL hit_change: got %b expected 0", rd_hit_o); end
      push(1'b1, 16'h0013, 10'd5, 32'hDEAD0001, 4'd3);
      checks++; if (wr_hit_o !== 1'b1) begin errors++; $display("FAIL wr_hit: got %b expected 1", wr_hit_o); end
      open_row_valid = 1'b0;
      #1;
      checks++; if (wr_hit_o !== 1'b0) begin errors++; $display("FAIL hit_closed: got %b expected 0", wr_hit_o); end
      open_row_valid = 1'b1;
      push(1'b0, 16'h0020, 10'd6, 32'h0, 4'd4);
      checks++; if (rd_count_o !== 4'd2 || wr_count_o !== 4'd1) begin
         errors++; $display("FAIL queued3: got rd=%0d wr=%0d expected 2/1", rd_count_o, wr_count_o); end
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      checks++; if (rd_valid_o !== 1'b0 || wr_valid_o !== 1'b0 || rd_count_o !== 4'd0 || wr_count_o !== 4'd0) begin
         errors++; $display("FAIL mid_reset: got rv=%b wv=%b rc=%0d wc=%0d expected all 0", rd_valid_o, wr_valid_o, rd_count_o, wr_count_o); end
      checks++; if (wr_hit_o !== 1'b0 || rd_hit_o !== 1'b0) begin
         errors++; $display("FAIL reset_hits: got rd=%b wr=%b expected 0/0", rd_hit_o, wr_hit_o); end
      $display("hit_reset: hit flags follow open_row, reset discards queued entries");
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_type = 1'b0; in_row = '0; in_col = '0;
      in_data = '0; in_index = '0; open_row = '0; open_row_valid = 1'b0;
      rd_pop = 1'b0; wr_pop = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_read_order();
      test_busy_overflow();
      test_full_push_pop();
      test_wrap();
      test_hit_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bank_request_buffer.md
Name: bank_request_buffer

Overview:
- Per-bank request storage directly downstream of the address mapper; 16 instances, one per {bank_group, bank}.
- Accepts mapped requests (row, column, data, index) on the mapper's per-bank valid strobe and sorts them into a read FIFO and a write FIFO.
- Drives a per-bank busy flag back to the mapper.
- Presents FIFO heads, with row-hit flags, to the bank scheduler, which pops them.

Parameters:
- ROW_W, 16, row address width
- COL_W, 10, column address width
- DATA_W, 32, write data width
- RD_IDX_W, 4, read index width (read_entries_log)
- WR_IDX_W, 4, write index width (write_entries_log)
- RD_DEPTH, 8, read FIFO entries, power of two, >=2
- WR_DEPTH, 8, write FIFO entries, power of two, >=2

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  mapper bank_out_valid bit for this bank
- in_type  in  1  0 = read, 1 = write
- in_row  in  ROW_W  request row
- in_col  in  COL_W  request column
- in_data  in  DATA_W  write data (ignored for reads)
- in_index  in  max(RD_IDX_W,WR_IDX_W)  mapper-assigned index; low RD_IDX_W/WR_IDX_W bits stored
- busy_o  out  1  to mapper in_busy bit
- open_row  in  ROW_W  currently open row in this bank
- open_row_valid  in  1  a row is open
- rd_valid_o  out  1  read FIFO non-empty
- rd_row_o / rd_col_o / rd_index_o  out  ROW_W/COL_W/RD_IDX_W  read head fields
- rd_hit_o  out  1  rd_valid_o & open_row_valid & (rd_row_o == open_row)
- rd_pop  in  1  scheduler consumes read head
- wr_valid_o  out  1  write FIFO non-empty
- wr_row_o / wr_col_o / wr_data_o / wr_index_o  out  ROW_W/COL_W/DATA_W/WR_IDX_W  write head fields
- wr_hit_o  out  1  as rd_hit_o, for the write head
- wr_pop  in  1  scheduler consumes write head
- rd_count_o  out  $clog2(RD_DEPTH)+1  read occupancy
- wr_count_o  out  $clog2(WR_DEPTH)+1  write occupancy
- overflow_err_o  out  1  sticky: a push arrived to a full FIFO

Behaviour:
- Reset (rst_n low at posedge): pointers, counts and overflow_err_o cleared. Hence all *_valid_o = 0, hit flags = 0, busy_o = 0, counts = 0. Head data outputs are don't-care while the FIFO is empty. Reset mid-operation discards all stored entries. FIFO data RAM is not reset.
- Push: at posedge with in_valid = 1, the entry is written to the read FIFO (in_type = 0) or the write FIFO (in_type = 1). Occupancy updates the same edge. The head is visible the next cycle (1-cycle write-to-head latency).
- Pop: at posedge with rd_pop & rd_valid_o, the read pointer advances; likewise for the write FIFO. A pop while empty is ignored, with no state change.
- Simultaneous push and pop on the same FIFO: both happen and the count is unchanged.
  - Allowed when full: the pop frees the slot, the push is accepted, no overflow.
  - When empty, the pushed entry becomes the head next cycle; the pop is ignored.
- Full push without a pop: entry dropped, count unchanged, overflow_err_o set to 1 and held until reset.
- busy_o is combinational from registered counts: (rd_count_o >= RD_DEPTH-1) | (wr_count_o >= WR_DEPTH-1).
  - This threshold covers the mapper's one-request-in-flight latency (busy sampled at t, request arrives at t+1).
  - Busy is per bank, not per type, matching the mapper's single in_busy bit.
- Heads are read combinationally from the RAM at the read pointer; no output register.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count is a separate register ranging 0..DEPTH.
- FIFO order is strict per type. No reordering between reads and writes inside this block.
- Hit flags are combinational and update the same cycle open_row or open_row_valid change.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> busy_o=0, rd/wr_valid_o=0, counts=0, overflow_err_o=0.
- Read ordering: push reads row 5/col 1/idx 0, row 6/col 2/idx 1 on consecutive cycles -> rd_count_o=2 at the next edge, head row 5 idx 0. Pop -> head row 6 idx 1. Pop -> rd_valid_o=0. Write FIFO unaffected.
- Busy threshold (RD_DEPTH=8): push 7 reads -> busy_o=1 when rd_count_o=7. Push an 8th -> count 8, no error. Push a 9th with no pop -> dropped, count 8, overflow_err_o=1 and held.
- Full plus simultaneous push/pop: write FIFO at 8, push data 0xA5A5A5A5 with wr_pop=1 -> count stays 8, no error. 0xA5A5A5A5 reaches the head after the 7 older entries are popped.
- Wrap-around: 20 writes interleaved with pops, occupancy kept at 1..3 -> data emerges in exact push order across 2+ pointer wraps.
- Row hit plus reset mid-operation: open_row=0x0012, open_row_valid=1, read head row 0x0012 -> rd_hit_o=1. Change open_row to 0x0013 -> rd_hit_o=0 the same cycle. Assert rst_n low with 3 entries queued -> all valids and counts 0 the next cycle.
